// File: rtl/trigger_pkg.sv
// rtl/trigger_pkg.sv - shared encodings and defaults for the trigger scheduler
package trigger_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BIT1 = 2'b01,
    ST_BIT0 = 2'b10
  } state_t;

  localparam int TAGW_DEF = 2;
  localparam int NREQ_DEF = 4;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick over requests starting at a pointer
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_Req,
  input  logic [PW-1:0]   i_Ptr,
  output logic [NREQ-1:0] o_Grant,
  output logic [PW-1:0]   o_Index
);
  logic w_found;
  int   w_pos;

  always_comb begin
    o_Grant = '0;
    o_Index = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = (int'(i_Ptr) + k) % NREQ;
      if (!w_found && i_Req[w_pos]) begin
        w_found        = 1'b1;
        o_Grant[w_pos] = 1'b1;
        o_Index        = PW'(w_pos);
      end
    end
  end
endmodule

// File: rtl/trigger_scheduler.sv
// rtl/trigger_scheduler.sv - tag-allocating trigger scheduler with 3-cycle serial frames
module trigger_scheduler
  import trigger_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NREQ-1:0]        i_Req,
  input  logic                   i_DoneValid,
  input  logic [TAGW-1:0]        i_DoneTag,
  output logic                   o_TrigOut,
  output logic [NREQ-1:0]        o_Grant,
  output logic [TAGW-1:0]        o_IssuedTag,
  output logic [(1<<TAGW)-1:0]   o_InUse,
  output logic                   o_Busy,
  output logic                   o_ErrDone
);
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NTAG = 1 << TAGW;

  state_t            r_state, w_state_nxt;
  logic              r_trig, w_trig_nxt;
  logic [NREQ-1:0]   r_grant, w_grant_nxt;
  logic [TAGW-1:0]   r_itag, w_itag_nxt;
  logic [TAGW-1:0]   r_cur_tag, w_cur_nxt;
  logic [TAGW-1:0]   r_next_tag, w_next_nxt;
  logic [PW-1:0]     r_ptr, w_ptr_nxt;
  logic [NTAG-1:0]   r_inuse, w_inuse_nxt, w_set, w_clr;
  logic              r_busy, r_err, w_err_nxt;
  logic              w_eligible;
  logic [NREQ-1:0]   w_arb_grant;
  logic [PW-1:0]     w_arb_idx;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .i_Req   (i_Req),
    .i_Ptr   (r_ptr),
    .o_Grant (w_arb_grant),
    .o_Index (w_arb_idx)
  );

  // Eligibility uses the pre-edge bitmap, so a tag freed this edge is only usable next cycle.
  assign w_eligible = (r_state == ST_IDLE) && (|i_Req) && !r_inuse[r_next_tag];

  always_comb begin
    w_state_nxt = r_state;
    w_trig_nxt  = 1'b0;
    w_grant_nxt = '0;
    w_itag_nxt  = r_itag;
    w_cur_nxt   = r_cur_tag;
    w_next_nxt  = r_next_tag;
    w_ptr_nxt   = r_ptr;
    w_set       = '0;
    w_clr       = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_eligible) begin
          w_trig_nxt        = 1'b1;
          w_grant_nxt       = w_arb_grant;
          w_itag_nxt        = r_next_tag;
          w_cur_nxt         = r_next_tag;
          w_set[r_next_tag] = 1'b1;
          w_next_nxt        = r_next_tag + 1'b1;
          w_ptr_nxt         = (w_arb_idx == PW'(NREQ - 1)) ? '0 : w_arb_idx + 1'b1;
          w_state_nxt       = ST_BIT1;
        end
      end
      ST_BIT1: begin
        w_trig_nxt  = r_cur_tag[1];
        w_state_nxt = ST_BIT0;
      end
      ST_BIT0: begin
        w_trig_nxt  = r_cur_tag[0];
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_DoneValid && r_inuse[i_DoneTag]) w_clr[i_DoneTag] = 1'b1;
    w_inuse_nxt = (r_inuse | w_set) & ~w_clr;
    w_err_nxt   = i_DoneValid && !r_inuse[i_DoneTag];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_trig     <= 1'b0;
      r_grant    <= '0;
      r_itag     <= '0;
      r_cur_tag  <= '0;
      r_next_tag <= '0;
      r_ptr      <= '0;
      r_inuse    <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_trig     <= w_trig_nxt;
      r_grant    <= w_grant_nxt;
      r_itag     <= w_itag_nxt;
      r_cur_tag  <= w_cur_nxt;
      r_next_tag <= w_next_nxt;
      r_ptr      <= w_ptr_nxt;
      r_inuse    <= w_inuse_nxt;
      r_busy     <= &w_inuse_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign o_TrigOut   = r_trig;
  assign o_Grant     = r_grant;
  assign o_IssuedTag = r_itag;
  assign o_InUse     = r_inuse;
  assign o_Busy      = r_busy;
  assign o_ErrDone   = r_err;
endmodule

// File: tb/tb_trigger_scheduler.sv
// tb/tb_trigger_scheduler.sv - self-checking bench for trigger_scheduler
module tb_trigger_scheduler;
  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] req;
  logic       dv;
  logic [1:0] dtag;
  logic       trig;
  logic [3:0] grant;
  logic [1:0] itag;
  logic [3:0] inuse;
  logic       busy;
  logic       err;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  trigger_scheduler dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .i_Req       (req),
    .i_DoneValid (dv),
    .i_DoneTag   (dtag),
    .o_TrigOut   (trig),
    .o_Grant     (grant),
    .o_IssuedTag (itag),
    .o_InUse     (inuse),
    .o_Busy      (busy),
    .o_ErrDone   (err)
  );

  // Reference: a frame is just three queued line bits; a new frame may start once the queue is empty.
  bit         m_bits[$];
  logic [3:0] m_inuse;
  int         m_next, m_ptr;
  logic       m_trig, m_busy, m_err;
  logic [3:0] m_grant;
  logic [1:0] m_itag;

  task automatic model_step();
    bit         elig;
    logic [3:0] ni;
    int         w;
    if (Reset) begin
      m_bits.delete();
      m_inuse = 4'b0; m_next = 0; m_ptr = 0; m_trig = 1'b0;
      m_grant = 4'b0; m_itag = 2'b0; m_busy = 1'b0; m_err = 1'b0;
    end else begin
      elig  = (m_bits.size() == 0) && (req != 4'b0) && !m_inuse[m_next];
      m_err = dv && !m_inuse[dtag];
      ni    = m_inuse;
      if (dv && m_inuse[dtag]) ni[dtag] = 1'b0;
      m_grant = 4'b0;
      if (elig) begin
        w = -1;
        for (int k = 0; k < 4; k++)
          if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        m_grant    = 4'b0001 << w;
        m_itag     = 2'(m_next);
        ni[m_next] = 1'b1;
        m_bits.push_back(1'b1);
        m_bits.push_back(m_next[1]);
        m_bits.push_back(m_next[0]);
        m_next = (m_next + 1) % 4;
        m_ptr  = (w + 1) % 4;
      end
      m_trig  = (m_bits.size() > 0) ? m_bits.pop_front() : 1'b0;
      m_inuse = ni;
      m_busy  = &ni;
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] q, input logic d, input logic [1:0] t);
    Reset = r; req = q; dv = d; dtag = t;
    @(posedge Clock);
    model_step();
    #1;
    total++;
    if ({trig, grant, itag, inuse, busy, err} !== {m_trig, m_grant, m_itag, m_inuse, m_busy, m_err}) begin
      bad++;
      $display("FAIL model t=%0t got trig=%b gnt=%b tag=%0d inuse=%b busy=%b err=%b want trig=%b gnt=%b tag=%0d inuse=%b busy=%b err=%b",
               $time, trig, grant, itag, inuse, busy, err, m_trig, m_grant, m_itag, m_inuse, m_busy, m_err);
    end
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic       d;
    logic [1:0] t;
    logic       e_trig;
    logic [3:0] e_gnt;
    logic [1:0] e_tag;
    logic [3:0] e_iu;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  vec_t        tbl[15];
  logic [11:0] trig_s;

  initial begin
    Reset = 1'b1; req = 4'b0; dv = 1'b0; dtag = 2'b0;
    // single pulse, bad release, then tags 0..2 outstanding, release 1, next tag is 3
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001, 2'd0, 4'b0001, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0, 4'b0001, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0, 4'b0001, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 2'd0, 4'b0001, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd0, 4'b0001, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001, 2'd1, 4'b0011, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 2'd1, 4'b0011, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 2'd1, 4'b0011, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001, 2'd2, 4'b0111, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 2'd2, 4'b0111, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000, 2'd2, 4'b0101, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'b0001, 1'b0, 2'd0, 1'b1, 4'b0001, 2'd3, 4'b1101, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000, 2'd3, 4'b1100, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 2'd3, 4'b1100, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].rst, tbl[i].rq, tbl[i].d, tbl[i].t);
      total++;
      if ({trig, grant, itag, inuse, busy, err} !==
          {tbl[i].e_trig, tbl[i].e_gnt, tbl[i].e_tag, tbl[i].e_iu, tbl[i].e_busy, tbl[i].e_err}) begin
        bad++;
        $display("FAIL vec%0d got trig=%b gnt=%b tag=%0d inuse=%b busy=%b err=%b want trig=%b gnt=%b tag=%0d inuse=%b busy=%b err=%b",
                 i, trig, grant, itag, inuse, busy, err, tbl[i].e_trig, tbl[i].e_gnt, tbl[i].e_tag,
                 tbl[i].e_iu, tbl[i].e_busy, tbl[i].e_err);
      end
    end

    // all four requesting, each tag released two cycles after issue
    cyc(1'b1, 4'b0, 1'b0, 2'd0);
    trig_s = 12'b0;
    for (int c = 0; c < 12; c++) begin
      cyc(1'b0, 4'b1111, (c % 3) == 2, 2'(c / 3));
      trig_s = {trig_s[10:0], trig};
      if ((c % 3) == 0) begin
        chk("rr_grant", 16'(grant), 16'(4'b0001 << (c / 3)));
        chk("rr_tag", 16'(itag), 16'(c / 3));
      end
    end
    chk("rr_trig_stream", 16'(trig_s), 16'(12'b100101110111));

    // all tags outstanding blocks grants until tag 0 is freed
    cyc(1'b1, 4'b0, 1'b0, 2'd0);
    for (int c = 0; c < 12; c++) cyc(1'b0, 4'b0001, 1'b0, 2'd0);
    chk("full_busy", 16'(busy), 16'd1);
    chk("full_inuse", 16'(inuse), 16'hF);
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 4'b0010, 1'b0, 2'd0);
      chk("full_nogrant", 16'(grant), 16'd0);
    end
    cyc(1'b0, 4'b0010, 1'b1, 2'd0);
    chk("free_same_cycle", 16'(grant), 16'd0);
    cyc(1'b0, 4'b0010, 1'b0, 2'd0);
    chk("free_next_grant", 16'(grant), 16'b0010);
    chk("free_next_tag", 16'(itag), 16'd0);

    // reset during BIT1 of the frame for tag 1
    cyc(1'b1, 4'b0, 1'b0, 2'd0);
    for (int c = 0; c < 4; c++) cyc(1'b0, 4'b0001, 1'b0, 2'd0);
    chk("pre_reset_tag", 16'(itag), 16'd1);
    cyc(1'b1, 4'b0001, 1'b1, 2'd0);
    chk("midreset_trig", 16'(trig), 16'd0);
    chk("midreset_inuse", 16'(inuse), 16'd0);
    cyc(1'b0, 4'b1111, 1'b0, 2'd0);
    chk("postreset_grant", 16'(grant), 16'b0001);
    chk("postreset_tag", 16'(itag), 16'd0);

    // random traffic against the reference
    for (int c = 0; c < 600; c++)
      cyc($urandom_range(0, 63) == 0, 4'($urandom), $urandom_range(0, 2) == 0, 2'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
